tmds_channel_encoder: RTL and testbench

- One TMDS channel encoder: 8b/10b DVI encoding of one colour component, plus control-period encoding of (c1,c0).
- Sits directly downstream of the display pixel path, one instance per R/G/B channel. Takes pixel data and timing signals in the i_p_clk domain and hands 10-bit symbols to the 10x serializer.
- Fully pipelined with fixed latency. Holds running-disparity state across a video active period.

---
 rtl/tmds_pkg.sv | 20 ++
 rtl/tmds_qm_stage.sv | 63 ++++++
 rtl/tmds_channel_encoder.sv | 83 ++++++++
 tb/tb_tmds_channel_encoder.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/tmds_pkg.sv
// rtl/tmds_pkg.sv - shared TMDS control codes, popcount helper and counter width
package tmds_pkg;

  localparam int TMDS_CNT_WIDTH = 5;

  localparam logic [9:0] CTRL_00 = 10'h354;
  localparam logic [9:0] CTRL_01 = 10'h0AB;
  localparam logic [9:0] CTRL_10 = 10'h154;
  localparam logic [9:0] CTRL_11 = 10'h2AB;

  function automatic logic [3:0] popcount8(input logic [7:0] x);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) begin
      n = n + {3'b000, x[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/tmds_qm_stage.sv
// rtl/tmds_qm_stage.sv - stage 1: transition-minimised q_m word plus its ones count
module tmds_qm_stage
  import tmds_pkg::*;
(
  input  logic       clk_i,
  input  logic       rstn_i,
  input  logic [7:0] data_i,
  input  logic       de_i,
  input  logic       c0_i,
  input  logic       c1_i,
  output logic [8:0] qm_o,
  output logic [3:0] n1_o,
  output logic       de_o,
  output logic       c0_o,
  output logic       c1_o
);

  // Chained XOR/XNOR kept in a function so the bit-to-bit dependency stays local.
  function automatic logic [8:0] tm_encode(input logic [7:0] d);
    logic [3:0] n1;
    logic       use_xnor;
    logic [8:0] q;
    n1       = popcount8(d);
    use_xnor = (n1 > 4'd4) || ((n1 == 4'd4) && !d[0]);
    q        = '0;
    q[0]     = d[0];
    for (int i = 1; i < 8; i++) begin
      q[i] = use_xnor ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
    end
    q[8] = ~use_xnor;
    return q;
  endfunction

  logic [8:0] qm_d, qm_q;
  logic [3:0] n1_d, n1_q;
  logic       de_q, c0_q, c1_q;

  assign qm_d = tm_encode(data_i);
  assign n1_d = popcount8(qm_d[7:0]);

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      qm_q <= '0;
      n1_q <= '0;
      de_q <= 1'b0;
      c0_q <= 1'b0;
      c1_q <= 1'b0;
    end else begin
      qm_q <= qm_d;
      n1_q <= n1_d;
      de_q <= de_i;
      c0_q <= c0_i;
      c1_q <= c1_i;
    end
  end

  assign qm_o = qm_q;
  assign n1_o = n1_q;
  assign de_o = de_q;
  assign c0_o = c0_q;
  assign c1_o = c1_q;

endmodule

// File: rtl/tmds_channel_encoder.sv
// rtl/tmds_channel_encoder.sv - one DVI TMDS channel: 8b/10b data and control-period encoding
module tmds_channel_encoder
  import tmds_pkg::*;
#(
  parameter int CNT_WIDTH = TMDS_CNT_WIDTH
) (
  input  logic       i_p_clk,
  input  logic       i_rstn,
  input  logic [7:0] i_data,
  input  logic       i_de,
  input  logic       i_c0,
  input  logic       i_c1,
  output logic [9:0] o_tmds
);

  typedef logic signed [CNT_WIDTH-1:0] cnt_t;

  logic [8:0] qm;
  logic [3:0] n1q, n0q;
  logic       de_s1, c0_s1, c1_s1;

  tmds_qm_stage u_qm_stage (
    .clk_i  (i_p_clk),
    .rstn_i (i_rstn),
    .data_i (i_data),
    .de_i   (i_de),
    .c0_i   (i_c0),
    .c1_i   (i_c1),
    .qm_o   (qm),
    .n1_o   (n1q),
    .de_o   (de_s1),
    .c0_o   (c0_s1),
    .c1_o   (c1_s1)
  );

  cnt_t       cnt_q, cnt_d, diff, two_qm8, two_nqm8;
  logic       cnt_pos, cnt_neg;
  logic [9:0] tmds_q, tmds_d;

  assign n0q      = 4'd8 - n1q;
  assign diff     = cnt_t'(n1q) - cnt_t'(n0q);
  assign two_qm8  = qm[8] ? cnt_t'(2) : '0;
  assign two_nqm8 = qm[8] ? '0 : cnt_t'(2);
  // Sign tests done on the MSB to keep every comparison explicitly signed.
  assign cnt_neg  = cnt_q[CNT_WIDTH-1];
  assign cnt_pos  = !cnt_q[CNT_WIDTH-1] && (cnt_q != '0);

  always_comb begin
    tmds_d = CTRL_00;
    cnt_d  = cnt_q;
    if (!de_s1) begin
      unique case ({c1_s1, c0_s1})
        2'b00:   tmds_d = CTRL_00;
        2'b01:   tmds_d = CTRL_01;
        2'b10:   tmds_d = CTRL_10;
        default: tmds_d = CTRL_11;
      endcase
      cnt_d = '0;
    end else if ((cnt_q == '0) || (n1q == n0q)) begin
      tmds_d = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
      cnt_d  = qm[8] ? (cnt_q + diff) : (cnt_q - diff);
    end else if ((cnt_pos && (n1q > n0q)) || (cnt_neg && (n0q > n1q))) begin
      tmds_d = {1'b1, qm[8], ~qm[7:0]};
      cnt_d  = cnt_q + two_qm8 - diff;
    end else begin
      tmds_d = {1'b0, qm[8], qm[7:0]};
      cnt_d  = cnt_q - two_nqm8 + diff;
    end
  end

  always_ff @(posedge i_p_clk) begin
    if (!i_rstn) begin
      tmds_q <= CTRL_00;
      cnt_q  <= '0;
    end else begin
      tmds_q <= tmds_d;
      cnt_q  <= cnt_d;
    end
  end

  assign o_tmds = tmds_q;

endmodule

// File: tb/tb_tmds_channel_encoder.sv
// tb/tb_tmds_channel_encoder.sv - scoreboard bench for tmds_channel_encoder
module tb_tmds_channel_encoder;

  logic       clk = 1'b0;
  logic       rstn;
  logic [7:0] data;
  logic       de, c0, c1;
  logic [9:0] tmds;

  always #5 clk = ~clk;

  tmds_channel_encoder dut (
    .i_p_clk (clk),
    .i_rstn  (rstn),
    .i_data  (data),
    .i_de    (de),
    .i_c0    (c0),
    .i_c1    (c1),
    .o_tmds  (tmds)
  );

  typedef struct {
    logic [9:0] sym;
    logic       de;
    logic [7:0] data;
    int         cnt;
  } exp_t;

  exp_t sb[$];
  int   m_cnt;
  int   n_assert;
  int   n_fail;

  task automatic check(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int ones8(input logic [7:0] x);
    int n;
    n = 0;
    for (int i = 0; i < 8; i++) n += int'(x[i]);
    return n;
  endfunction

  function automatic logic [9:0] model(input logic [7:0] d, input logic de_v,
                                       input logic c1_v, input logic c0_v, inout int cnt);
    logic [8:0] qm;
    logic       xn;
    int         n1, n0;
    logic [9:0] sym;
    if (!de_v) begin
      cnt = 0;
      case ({c1_v, c0_v})
        2'b00:   return 10'h354;
        2'b01:   return 10'h0AB;
        2'b10:   return 10'h154;
        default: return 10'h2AB;
      endcase
    end
    xn    = (ones8(d) > 4) || (ones8(d) == 4 && d[0] == 1'b0);
    qm    = '0;
    qm[0] = d[0];
    for (int i = 1; i < 8; i++) qm[i] = xn ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
    qm[8] = !xn;
    n1    = ones8(qm[7:0]);
    n0    = 8 - n1;
    if (cnt == 0 || n1 == n0) begin
      sym = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
      cnt += qm[8] ? (n1 - n0) : (n0 - n1);
    end else if ((cnt > 0 && n1 > n0) || (cnt < 0 && n0 > n1)) begin
      sym = {1'b1, qm[8], ~qm[7:0]};
      cnt += (qm[8] ? 2 : 0) + n0 - n1;
    end else begin
      sym = {1'b0, qm[8], qm[7:0]};
      cnt += (qm[8] ? 0 : -2) + n1 - n0;
    end
    return sym;
  endfunction

  function automatic logic [7:0] decode(input logic [9:0] s);
    logic [7:0] d, o;
    d    = s[9] ? ~s[7:0] : s[7:0];
    o[0] = d[0];
    for (int i = 1; i < 8; i++) o[i] = s[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
    return o;
  endfunction

  task automatic pop_check();
    exp_t e;
    int   dcnt;
    if (sb.size() == 0) begin
      n_assert++;
      n_fail++;
      $display("FAIL scoreboard_empty: observed 0 entries expected 1");
      return;
    end
    e    = sb.pop_front();
    dcnt = int'($signed(dut.cnt_q));
    check("sym", int'(tmds), int'(e.sym));
    check("cnt", dcnt, e.cnt);
    check("cnt_bound", int'(dcnt >= -10 && dcnt <= 10), 1);
    if (e.de) check("decode", int'(decode(tmds)), int'(e.data));
  endtask

  task automatic drive(input logic [7:0] d, input logic de_v, input logic c1_v,
                       input logic c0_v, input logic use_gold, input logic [9:0] gold,
                       input int gold_cnt);
    exp_t e;
    data   = d;
    de     = de_v;
    c1     = c1_v;
    c0     = c0_v;
    e.sym  = model(d, de_v, c1_v, c0_v, m_cnt);
    e.cnt  = m_cnt;
    e.de   = de_v;
    e.data = d;
    if (use_gold) begin
      e.sym = gold;
      e.cnt = gold_cnt;
      m_cnt = gold_cnt;
    end
    sb.push_back(e);
    @(posedge clk);
    #1;
    pop_check();
  endtask

  task automatic step(input logic [7:0] d, input logic de_v, input logic c1_v, input logic c0_v);
    drive(d, de_v, c1_v, c0_v, 1'b0, 10'h000, 0);
  endtask

  task automatic step_gold(input logic [7:0] d, input logic de_v, input logic c1_v,
                           input logic c0_v, input logic [9:0] gold, input int gold_cnt);
    drive(d, de_v, c1_v, c0_v, 1'b1, gold, gold_cnt);
  endtask

  // Reset discards whatever is in flight; two reset-value symbols follow.
  task automatic step_reset(input logic [7:0] d, input logic de_v);
    exp_t e;
    rstn   = 1'b0;
    data   = d;
    de     = de_v;
    c1     = 1'b1;
    c0     = 1'b1;
    e.sym  = 10'h354;
    e.cnt  = 0;
    e.de   = 1'b0;
    e.data = 8'h00;
    sb.delete();
    sb.push_back(e);
    sb.push_back(e);
    m_cnt = 0;
    @(posedge clk);
    #1;
    pop_check();
    rstn = 1'b1;
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    m_cnt    = 0;
    rstn     = 1'b0;
    data     = 8'h00;
    de       = 1'b0;
    c0       = 1'b0;
    c1       = 1'b0;

    repeat (3) step_reset(8'hA5, 1'b1);

    step_gold(8'h11, 1'b0, 1'b0, 1'b1, 10'h0AB, 0);
    step_gold(8'h22, 1'b0, 1'b1, 1'b0, 10'h154, 0);
    step_gold(8'h33, 1'b0, 1'b1, 1'b1, 10'h2AB, 0);
    step_gold(8'h44, 1'b0, 1'b0, 1'b0, 10'h354, 0);

    step_gold(8'h00, 1'b1, 1'b1, 1'b1, 10'h100, -8);
    step_gold(8'h00, 1'b1, 1'b0, 1'b1, 10'h3FF, 2);
    step_gold(8'h00, 1'b1, 1'b1, 1'b0, 10'h100, -6);
    step_gold(8'h00, 1'b0, 1'b0, 1'b0, 10'h354, 0);
    step_gold(8'hFF, 1'b1, 1'b0, 1'b0, 10'h200, -8);
    step(8'h00, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 640; i++) step(8'($urandom), 1'b1, 1'($urandom), 1'($urandom));
    step_gold(8'h5A, 1'b0, 1'b0, 1'b1, 10'h0AB, 0);
    step(8'h00, 1'b0, 1'b0, 1'b1);

    for (int i = 0; i < 200; i++) begin
      if (i == 50) step_reset(8'($urandom), 1'b1);
      else step(8'($urandom), 1'b1, 1'b0, 1'b0);
    end
    step(8'h00, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 20000; i++) begin
      step(8'($urandom), 1'($urandom_range(0, 7) != 0), 1'($urandom), 1'($urandom));
    end
    step(8'h00, 1'b0, 1'b0, 1'b0);
    step(8'h00, 1'b0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
